// File: rtl/button_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// default timing parameters (cycle counts at a 50 MHz clock).
package button_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    PRESS_CHK   = 2'b01,
    HELD        = 2'b10,
    RELEASE_CHK = 2'b11
  } state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd500_000;    // 10 ms
  localparam int unsigned REPEAT_DELAY_DEF    = 32'd25_000_000; // 500 ms
  localparam int unsigned REPEAT_PERIOD_DEF   = 32'd15_000_000; // 300 ms

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit; the reset value
// lets the caller choose the "inactive" level seen while in reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounces an active-low push-button and produces a held level plus press,
// auto-repeat and release strobes, all driven straight from flops.
module button_debouncer
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic botao,
  output logic pressed,
  output logic press_pulse,
  output logic repeat_pulse,
  output logic release_pulse
);

  localparam logic [31:0] DEB_LAST       = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] REP_FIRST_LAST = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] REP_NEXT_LAST  = 32'(REPEAT_PERIOD - 1);

  logic        botao_sync;
  logic        s;
  state_t      state_q, state_d;
  logic [31:0] deb_q, deb_d;
  logic [31:0] rep_q, rep_d;
  logic        first_q, first_d;
  logic        pressed_d, press_d, repeat_d, release_d;

  // Reset to 1 so the button reads as released while reset is applied.
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (botao),
    .q     (botao_sync)
  );

  assign s = ~botao_sync;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    rep_d     = rep_q;
    first_d   = first_q;
    press_d   = 1'b0;
    repeat_d  = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_CHK;
          deb_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!s) begin
          state_d = IDLE;
        end else if (deb_q == DEB_LAST) begin
          state_d = HELD;
          press_d = 1'b1;
          rep_d   = '0;
          first_d = 1'b1;
        end else begin
          deb_d = deb_q + 32'd1;
        end
      end
      HELD: begin
        if (!s) begin
          state_d = RELEASE_CHK;
          deb_d   = '0;
        end else if (rep_q == (first_q ? REP_FIRST_LAST : REP_NEXT_LAST)) begin
          repeat_d = REPEAT_EN;
          rep_d    = '0;
          first_d  = 1'b0;
        end else begin
          rep_d = rep_q + 32'd1;
        end
      end
      RELEASE_CHK: begin
        // A short glitch returns to HELD with the repeat timing untouched.
        if (s) begin
          state_d = HELD;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          deb_d = deb_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    pressed_d = (state_d == HELD) || (state_d == RELEASE_CHK);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      deb_q         <= '0;
      rep_q         <= '0;
      first_q       <= 1'b1;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      deb_q         <= deb_d;
      rep_q         <= rep_d;
      first_q       <= first_d;
      pressed       <= pressed_d;
      press_pulse   <= press_d;
      repeat_pulse  <= repeat_d;
      release_pulse <= release_d;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench: a run-length model of the debouncer predicts pulse events
// into queues; a negedge monitor pops and compares them against two DUTs.
module tb_button_debouncer;

  localparam int D      = 4;
  localparam int DELAY  = 10;
  localparam int PERIOD = 6;

  typedef enum int {K_NONE, K_PRESS, K_REPEAT, K_RELEASE} kind_e;
  typedef struct {
    int    cyc;
    kind_e kind;
  } ev_t;

  logic clock;
  logic reset;
  logic botao;
  logic pressed_a, press_a, repeat_a, release_a;
  logic pressed_b, press_b, repeat_b, release_b;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  ev_t q_rep[$];
  ev_t q_norep[$];

  // Model state: synchronizer image, accepted level, length of the current run
  // of samples disagreeing with it, and held time for the repeat schedule.
  bit sy1 = 1'b1, sy2 = 1'b1;
  bit acc = 1'b0;
  bit exp_pressed = 1'b0;
  int run = 0;
  int ticks = 0;
  int next_rep = 0;

  button_debouncer #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD), .REPEAT_EN(1'b1)
  ) dut_rep (
    .clock(clock), .reset(reset), .botao(botao),
    .pressed(pressed_a), .press_pulse(press_a),
    .repeat_pulse(repeat_a), .release_pulse(release_a)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD), .REPEAT_EN(1'b0)
  ) dut_norep (
    .clock(clock), .reset(reset), .botao(botao),
    .pressed(pressed_b), .press_pulse(press_b),
    .repeat_pulse(repeat_b), .release_pulse(release_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic push(input kind_e k);
    ev_t e;
    e.cyc  = cyc;
    e.kind = k;
    q_rep.push_back(e);
    if (k != K_REPEAT) q_norep.push_back(e);
  endtask

  // Acceptance needs D+1 consecutive agreeing samples; repeats fire when the
  // uninterrupted held time reaches DELAY, then every PERIOD after that.
  task automatic model_step();
    bit s;
    cyc++;
    if (reset) begin
      sy1 = 1'b1; sy2 = 1'b1;
      acc = 1'b0; run = 0; ticks = 0; next_rep = 0;
    end else begin
      s   = !sy2;
      sy2 = sy1;
      sy1 = botao;
      if (!acc) begin
        run = s ? run + 1 : 0;
        if (run == D + 1) begin
          acc = 1'b1; run = 0; ticks = 0; next_rep = DELAY;
          push(K_PRESS);
        end
      end else if (!s) begin
        run++;
        if (run == D + 1) begin
          acc = 1'b0; run = 0;
          push(K_RELEASE);
        end
      end else if (run != 0) begin
        run = 0;
      end else begin
        ticks++;
        if (ticks == next_rep) begin
          next_rep += PERIOD;
          push(K_REPEAT);
        end
      end
    end
    exp_pressed = acc;
  endtask

  task automatic mon(input int id, input logic pr, input logic pp, input logic rp,
                     input logic rl);
    kind_e act;
    ev_t   e;
    bit    have;
    act  = pp ? K_PRESS : rp ? K_REPEAT : rl ? K_RELEASE : K_NONE;
    have = (id == 0) ? (q_rep.size() > 0) : (q_norep.size() > 0);
    if (have) e = (id == 0) ? q_rep[0] : q_norep[0];
    if (act != K_NONE) begin
      check($sformatf("pulse_onehot[%0d]", id), int'(pp) + int'(rp) + int'(rl), 1);
      if (!have) begin
        check($sformatf("unexpected_pulse[%0d]", id), act, K_NONE);
      end else begin
        if (id == 0) void'(q_rep.pop_front()); else void'(q_norep.pop_front());
        check($sformatf("pulse_kind[%0d]", id), act, e.kind);
        check($sformatf("pulse_cycle[%0d]", id), cyc, e.cyc);
      end
    end else if (have && e.cyc <= cyc) begin
      check($sformatf("missing_pulse[%0d]", id), act, e.kind);
      if (id == 0) void'(q_rep.pop_front()); else void'(q_norep.pop_front());
    end
    check($sformatf("pressed[%0d]", id), pr, exp_pressed);
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    mon(0, pressed_a, press_a, repeat_a, release_a);
    mon(1, pressed_b, press_b, repeat_b, release_b);
  end

  // Inputs change just after the falling edge, well clear of the sampling edge.
  task automatic hold(input logic b, input int n);
    botao = b;
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    botao = 1'b1;
    @(negedge clock);
    #1;
    hold(1'b1, 3);
    reset = 1'b0;
    hold(1'b1, 5);

    // Clean press, long hold through several repeats, clean release.
    hold(1'b0, 50);
    hold(1'b1, 15);
    // Bounce on the way in, then a two-cycle glitch while held.
    hold(1'b0, 3);
    hold(1'b1, 1);
    hold(1'b0, 20);
    hold(1'b1, 2);
    hold(1'b0, 25);
    hold(1'b1, 15);
    // Reset while held, button still down afterwards.
    hold(1'b0, 15);
    reset = 1'b1;
    hold(1'b0, 3);
    reset = 1'b0;
    hold(1'b0, 20);
    hold(1'b1, 15);

    for (int i = 0; i < 40; i++) begin
      int len;
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4))
                                        : int'($urandom_range(5, 40));
      if ($urandom_range(0, 11) == 0) begin
        reset = 1'b1;
        hold(logic'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
        reset = 1'b0;
      end
      hold(logic'($urandom_range(0, 1)), len);
    end

    hold(1'b1, 30);
    check("q_rep_drain", q_rep.size(), 0);
    check("q_norep_drain", q_norep.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
